simple_spi_slave: RTL and testbench

- SPI slave in mode 0 (CPOL=0, CPHA=0), MSB first, with a parameterised word width.
- All SPI pins are asynchronous. They are synchronised into the single system clock domain and edge-detected there.
- Each received word is presented as a parallel value with a one-cycle valid strobe. The word to transmit is taken from a parallel input.
- Sits between the FPGA pins and user logic, such as a register file or command decoder.

---
 rtl/simple_spi_slave_pkg.sv | 14 +
 rtl/simple_spi_slave_pin_sync.sv | 34 +++
 rtl/simple_spi_slave.sv | 132 +++++++++++++
 tb/tb_simple_spi_slave.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/simple_spi_slave_pkg.sv
// Shared constants and types for the mode-0 SPI slave: the idle levels
// the pin synchronisers reset to, and the selection state of the link.
package simple_spi_slave_pkg;

  localparam logic NCS_IDLE  = 1'b1;
  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

  typedef enum logic {
    LINK_IDLE = 1'b0,
    LINK_SEL  = 1'b1
  } link_t;

endpackage

// File: rtl/simple_spi_slave_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus a third flop
// so rising and falling edges can be detected in the system clock domain.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      hist_p2 <= RST_VAL;
    end else begin
      meta_p0 <= pin;
      sync_p1 <= meta_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~hist_p2;
  assign fall  = ~sync_p1 & hist_p2;

endmodule

// File: rtl/simple_spi_slave.sv
// SPI mode-0 slave, MSB first: receives WIDTH-bit words from MOSI into a
// parallel register with a valid strobe and shifts value_miso out on MISO.
module simple_spi_slave
  import simple_spi_slave_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             system_clk,
  input  logic             system_rst_n,
  input  logic             pin_ncs,
  input  logic             pin_clk,
  input  logic             pin_mosi,
  output logic             pin_miso,
  output logic             pin_miso_en,
  input  logic [WIDTH-1:0] value_miso,
  output logic [WIDTH-1:0] value_mosi,
  output logic             cs_start,
  output logic             cs_stop,
  output logic             value_valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync #(.RST_VAL(NCS_IDLE)) u_sync_ncs (
    .clk   (system_clk),
    .rst_n (system_rst_n),
    .pin   (pin_ncs),
    .level (ncs_lvl),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  spi_pin_sync #(.RST_VAL(SCK_IDLE)) u_sync_sck (
    .clk   (system_clk),
    .rst_n (system_rst_n),
    .pin   (pin_clk),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_pin_sync #(.RST_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk   (system_clk),
    .rst_n (system_rst_n),
    .pin   (pin_mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Only MOSI's level is sampled; the SCK level and MOSI edges are not needed.
  logic unused_sync;
  assign unused_sync = &{sck_lvl, mosi_rise, mosi_fall};

  link_t            state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic             reload_pend;
  logic [WIDTH-1:0] rx_next;
  logic             active;

  assign rx_next = {rx_sr[WIDTH-2:0], mosi_lvl};
  assign active  = (state == LINK_SEL) && !ncs_lvl;

  always_ff @(posedge system_clk) begin
    if (!system_rst_n) begin
      state       <= LINK_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      reload_pend <= 1'b0;
      pin_miso    <= 1'b0;
      pin_miso_en <= 1'b0;
      value_mosi  <= '0;
      cs_start    <= 1'b0;
      cs_stop     <= 1'b0;
      value_valid <= 1'b0;
    end else begin
      cs_start    <= 1'b0;
      cs_stop     <= 1'b0;
      value_valid <= 1'b0;
      // Deselect wins over select so a glitchy CS never leaves MISO driven.
      if (ncs_rise) begin
        state       <= LINK_IDLE;
        cs_stop     <= 1'b1;
        pin_miso    <= 1'b0;
        pin_miso_en <= 1'b0;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (ncs_fall) begin
        state       <= LINK_SEL;
        cs_start    <= 1'b1;
        bit_cnt     <= '0;
        rx_sr       <= '0;
        tx_sr       <= value_miso;
        pin_miso    <= value_miso[WIDTH-1];
        pin_miso_en <= 1'b1;
        reload_pend <= 1'b0;
      end else if (active) begin
        if (sck_rise) begin
          rx_sr <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt     <= '0;
            value_mosi  <= rx_next;
            value_valid <= 1'b1;
            tx_sr       <= value_miso;
            reload_pend <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (sck_fall) begin
          // tx_sr[WIDTH-1] always mirrors the bit on pin_miso; a fresh word
          // is presented unshifted on the first fall after it was loaded.
          if (reload_pend) begin
            pin_miso    <= tx_sr[WIDTH-1];
            reload_pend <= 1'b0;
          end else begin
            tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
            pin_miso <= tx_sr[WIDTH-2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_spi_slave.sv
// Bench for simple_spi_slave (WIDTH=4): a bit-banged SPI master drives frames,
// a scoreboard queue holds expected received words, a monitor checks strobes.
module tb_simple_spi_slave;

  localparam int W    = 4;
  localparam int HALF = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pin_ncs = 1'b1;
  logic         pin_clk = 1'b0;
  logic         pin_mosi = 1'b0;
  logic         pin_miso;
  logic         pin_miso_en;
  logic [W-1:0] value_miso = '0;
  logic [W-1:0] value_mosi;
  logic         cs_start;
  logic         cs_stop;
  logic         value_valid;

  simple_spi_slave #(.WIDTH(W)) dut (
    .system_clk   (clk),
    .system_rst_n (rst_n),
    .pin_ncs      (pin_ncs),
    .pin_clk      (pin_clk),
    .pin_mosi     (pin_mosi),
    .pin_miso     (pin_miso),
    .pin_miso_en  (pin_miso_en),
    .value_miso   (value_miso),
    .value_mosi   (value_mosi),
    .cs_start     (cs_start),
    .cs_stop      (cs_stop),
    .value_valid  (value_valid)
  );

  always #1 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_mosi = '0;
  int           n_start = 0, n_stop = 0;
  int           exp_start = 0, exp_stop = 0;
  logic         in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe counting, MISO enable window and scoreboard pops.
  always @(negedge clk) begin
    logic exp_en;
    logic [W-1:0] exp_word;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (cs_start) n_start++;
      if (cs_stop) n_stop++;
      exp_en = cs_stop ? 1'b0 : (cs_start ? 1'b1 : in_frame);
      in_frame = exp_en;
      check("miso_en", 32'(pin_miso_en), 32'(exp_en));
      if (value_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(value_mosi), 32'hFFFF_FFFF);
        end else begin
          exp_word = sb.pop_front();
          check("value_mosi", 32'(value_mosi), 32'(exp_word));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic cs_low();
    pin_ncs = 1'b0;
    exp_start++;
    wait_cyc(HALF);
  endtask

  task automatic cs_high();
    wait_cyc(HALF);
    pin_ncs = 1'b1;
    exp_stop++;
    wait_cyc(HALF);
  endtask

  // Master: MOSI changes at start of SCK low, MISO sampled at SCK rise.
  task automatic send_word(input logic [W-1:0] mosi, input logic [W-1:0] miso_exp,
                           input logic [W-1:0] next_miso, input int nbits);
    logic [W-1:0] got;
    got = '0;
    if (nbits == W) begin
      sb.push_back(mosi);
      last_mosi = mosi;
    end
    for (int i = W - 1; i >= W - nbits; i--) begin
      pin_mosi = mosi[i];
      wait_cyc(HALF);
      pin_clk = 1'b1;
      got[i] = pin_miso;
      if (i == W - 1) value_miso = next_miso;
      wait_cyc(HALF);
      pin_clk = 1'b0;
    end
    if (nbits == W) check("miso_word", 32'(got), 32'(miso_exp));
  endtask

  task automatic check_strobes();
    check("cs_start_count", 32'(n_start), 32'(exp_start));
    check("cs_stop_count", 32'(n_stop), 32'(exp_stop));
  endtask

  task automatic run_frame(input logic [W-1:0] mosi, input logic [W-1:0] miso);
    value_miso = miso;
    cs_low();
    send_word(mosi, miso, miso, W);
    cs_high();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check_strobes();
  endtask

  // {mosi, miso} pairs
  logic [7:0] sweep [12] = '{
    8'b0000_1111, 8'b0101_1010, 8'b1111_0000,
    8'b0001_1000, 8'b0010_0100, 8'b0100_0010, 8'b1000_0001,
    8'b1110_0111, 8'b1101_1011, 8'b1011_1101, 8'b0111_1110,
    8'b1110_1110
  };

  initial begin
    wait_cyc(5);
    @(negedge clk);
    check("rst_miso", 32'(pin_miso), 32'd0);
    check("rst_miso_en", 32'(pin_miso_en), 32'd0);
    check("rst_value_mosi", 32'(value_mosi), 32'd0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_cs_start", 32'(cs_start), 32'd0);
    check("rst_cs_stop", 32'(cs_stop), 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);
    check_strobes();

    run_frame(4'b0110, 4'b1010);
    check("hold_after_frame", 32'(value_mosi), 32'b0110);

    foreach (sweep[k]) run_frame(sweep[k][7:4], sweep[k][3:0]);

    // Two words back-to-back in one frame, value_miso updated mid-word.
    value_miso = 4'b1001;
    cs_low();
    send_word(4'b0011, 4'b1001, 4'b0110, W);
    send_word(4'b1100, 4'b0110, 4'b0110, W);
    cs_high();
    check("two_word_drained", 32'(sb.size()), 32'd0);
    check("two_word_last", 32'(value_mosi), 32'b1100);
    check_strobes();

    // Abort after two bits: nothing delivered, value_mosi held.
    value_miso = 4'b0101;
    cs_low();
    send_word(4'b1011, 4'b0000, 4'b0101, 2);
    cs_high();
    check("abort_hold", 32'(value_mosi), 32'(last_mosi));
    check_strobes();
    run_frame(4'b1001, 4'b0110);

    // Reset mid-frame.
    value_miso = 4'b0011;
    cs_low();
    send_word(4'b1111, 4'b0000, 4'b0011, 2);
    rst_n = 1'b0;
    pin_ncs = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    check("mid_rst_miso", 32'(pin_miso), 32'd0);
    check("mid_rst_miso_en", 32'(pin_miso_en), 32'd0);
    check("mid_rst_value_mosi", 32'(value_mosi), 32'd0);
    check("mid_rst_valid", 32'(value_valid), 32'd0);
    check("mid_rst_cs_start", 32'(cs_start), 32'd0);
    check("mid_rst_cs_stop", 32'(cs_stop), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);
    check_strobes();
    run_frame(4'b1101, 4'b1011);

    check("final_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
